// File: rtl/axilite_reg_slave.sv
// AXI4-Lite register bank responder: NUM_REGS read/write registers with byte
// strobes, OKAY/SLVERR responses, parallel register outputs and write pulses.
module axilite_reg_slave #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          s_axil_awaddr,
    input  logic                           s_axil_awvalid,
    output logic                           s_axil_awready,
    input  logic [DATA_WIDTH-1:0]          s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_axil_wstrb,
    input  logic                           s_axil_wvalid,
    output logic                           s_axil_wready,
    output logic [1:0]                     s_axil_bresp,
    output logic                           s_axil_bvalid,
    input  logic                           s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axil_araddr,
    input  logic                           s_axil_arvalid,
    output logic                           s_axil_arready,
    output logic [DATA_WIDTH-1:0]          s_axil_rdata,
    output logic [1:0]                     s_axil_rresp,
    output logic                           s_axil_rvalid,
    input  logic                           s_axil_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned OFFS_W = $clog2(STRB_W);
    localparam int unsigned IDX_W  = ADDR_WIDTH - OFFS_W;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Held write beats waiting for their partner channel
    logic                  aw_held;
    logic [IDX_W-1:0]      aw_idx_q;
    logic                  w_held;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  commit;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]     w_strb;
    logic                  w_in_range;
    logic [IDX_W-1:0]      ar_idx;
    logic                  ar_in_range;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  unused_addr_bits;

    // Byte-offset address bits carry no information for word registers
    assign unused_addr_bits = ^{s_axil_awaddr[OFFS_W-1:0], s_axil_araddr[OFFS_W-1:0]};

    // Ready signals depend only on registered state
    assign s_axil_awready = !aw_held && !s_axil_bvalid;
    assign s_axil_wready  = !w_held && !s_axil_bvalid;
    assign s_axil_arready = !s_axil_rvalid;

    assign aw_hs  = s_axil_awvalid && s_axil_awready;
    assign w_hs   = s_axil_wvalid && s_axil_wready;
    assign ar_hs  = s_axil_arvalid && s_axil_arready;
    assign commit = (aw_held || aw_hs) && (w_held || w_hs) && !s_axil_bvalid;

    // Effective write beat: held copy if already captured, else live bus
    assign w_idx      = aw_held ? aw_idx_q : s_axil_awaddr[ADDR_WIDTH-1:OFFS_W];
    assign w_data     = w_held ? w_data_q : s_axil_wdata;
    assign w_strb     = w_held ? w_strb_q : s_axil_wstrb;
    assign w_in_range = 32'(w_idx) < NUM_REGS;

    assign ar_idx      = s_axil_araddr[ADDR_WIDTH-1:OFFS_W];
    assign ar_in_range = 32'(ar_idx) < NUM_REGS;

    // Read mux over the register bank
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (ar_idx == IDX_W'(i)) rd_val = regs[i];
        end
    end

    // Flatten register bank onto the parallel output bus
    always_comb begin
        regs_o = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
        end
    end

    // Write-channel capture flags and B response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held       <= 1'b0;
            aw_idx_q      <= '0;
            w_held        <= 1'b0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= RESP_OKAY;
        end else begin
            if (s_axil_bvalid && s_axil_bready) s_axil_bvalid <= 1'b0;
            if (commit) begin
                aw_held       <= 1'b0;
                w_held        <= 1'b0;
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= w_in_range ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_hs) begin
                    aw_held  <= 1'b1;
                    aw_idx_q <= s_axil_awaddr[ADDR_WIDTH-1:OFFS_W];
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= s_axil_wdata;
                    w_strb_q <= s_axil_wstrb;
                end
            end
        end
    end

    // Register bank update with byte strobes and per-register write pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_pulse_o <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
        end else begin
            wr_pulse_o <= '0;
            if (commit && w_in_range) begin
                for (int i = 0; i < int'(NUM_REGS); i++) begin
                    if (w_idx == IDX_W'(i)) begin
                        wr_pulse_o[i] <= 1'b1;
                        for (int b = 0; b < int'(STRB_W); b++) begin
                            if (w_strb[b]) regs[i][b*8 +: 8] <= w_data[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read response: data sampled in the AR handshake cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= '0;
            s_axil_rresp  <= RESP_OKAY;
        end else begin
            if (s_axil_rvalid && s_axil_rready) s_axil_rvalid <= 1'b0;
            if (ar_hs) begin
                s_axil_rvalid <= 1'b1;
                s_axil_rdata  <= ar_in_range ? rd_val : '0;
                s_axil_rresp  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

endmodule

// File: doc/axilite_reg_slave.md
Name: axilite_reg_slave

Overview:
AXI4-Lite responder (slave) exposing a bank of NUM_REGS read/write registers to fabric logic. It terminates transactions from an AXI-Lite master (the axilite agent in master mode in benches), decodes addresses, applies byte strobes and returns OKAY/SLVERR responses. It sits at the control-plane boundary of a design: register contents drive fabric logic in parallel, and a per-register write pulse flags updates.

Parameters:
ADDR_WIDTH, 8, byte address width of AW/AR channels
DATA_WIDTH, 32, data width; 32 or 64 only
NUM_REGS, 16, number of registers; 1..2^(ADDR_WIDTH-log2(DATA_WIDTH/8))

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
s_axil_awaddr  in  ADDR_WIDTH  write address
s_axil_awvalid  in  1  write address valid
s_axil_awready  out  1  write address ready
s_axil_wdata  in  DATA_WIDTH  write data
s_axil_wstrb  in  DATA_WIDTH/8  byte write strobes
s_axil_wvalid  in  1  write data valid
s_axil_wready  out  1  write data ready
s_axil_bresp  out  2  write response (2'b00 OKAY, 2'b10 SLVERR)
s_axil_bvalid  out  1  write response valid
s_axil_bready  in  1  write response ready
s_axil_araddr  in  ADDR_WIDTH  read address
s_axil_arvalid  in  1  read address valid
s_axil_arready  out  1  read address ready
s_axil_rdata  out  DATA_WIDTH  read data
s_axil_rresp  out  2  read response
s_axil_rvalid  out  1  read data valid
s_axil_rready  in  1  read data ready
regs_o  out  NUM_REGS*DATA_WIDTH  register contents, reg i at bits [i*DATA_WIDTH +: DATA_WIDTH]
wr_pulse_o  out  NUM_REGS  one-cycle pulse, bit i set in the cycle after reg i is written

Behaviour:
- Reset (async assert, sync release): all registers 0; bvalid, rvalid, wr_pulse_o = 0; bresp, rresp, rdata = 0; AW/W capture flags cleared; awready, wready, arready = 1 in the first cycle after release.
- Decode: index = addr[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]; low byte-offset bits ignored (unaligned treated as aligned). index >= NUM_REGS -> SLVERR.
- Write path, one outstanding write: AW and W accepted independently in either order or in the same cycle; awready = !aw_held && !bvalid; wready = !w_held && !bvalid. Accepted beat is held until its partner arrives.
- Commit at the clock edge ending the cycle in which the second of AW/W handshakes (same-cycle counts): in-range -> bytes with wstrb=1 updated, others kept, bresp=OKAY; out-of-range -> no register change, bresp=SLVERR. bvalid rises the next cycle, with regs_o already updated and wr_pulse_o[i] high for exactly that cycle. wstrb=0 in range: OKAY, no change, pulse still issued.
- bvalid held with bresp stable until bready; after the bvalid&&bready cycle, awready/wready return to 1 next cycle. Minimum write turnaround: 2 cycles per transaction with bready tied high.
- Read path, independent of write path, one outstanding read: arready = !rvalid. On AR handshake, rdata/rresp registered; rvalid=1 next cycle (latency 1). Out-of-range: rdata=0, rresp=SLVERR. rdata/rresp stable while rvalid && !rready; arready returns 1 the cycle after the R handshake.
- Read/write collision on the same register: read samples the value present in its AR handshake cycle; a write committing at the same edge is not visible to that read.
- Reset mid-transaction: all held beats and pending responses discarded; no response issued afterward.
- No combinational path from any input to any ready/valid output except through the held flags and bvalid/rvalid registers.

Test Plan:
- Write 0xDEADBEEF to 0x04, wstrb=0xF, AW and W same cycle, bready=1 -> bvalid one cycle later, bresp=OKAY, reg1=0xDEADBEEF, wr_pulse_o=0x0002 for 1 cycle; read 0x04 -> rdata=0xDEADBEEF, rresp=OKAY.
- W presented 3 cycles before AW (addr 0x08, data 0x12345678, wstrb=0x5) -> wready drops after W accept, no commit until AW; reg2=0x00340078.
- Write and read to 0x40 (index 16, NUM_REGS=16) -> bresp=SLVERR, rresp=SLVERR, rdata=0, regs_o unchanged, wr_pulse_o=0.
- Hold bready=0 for 5 cycles after a write -> bvalid/bresp stable, awready=wready=0 throughout, second AW stalls until 1 cycle after B handshake.
- AR to reg3 (value 0xA) in the same cycle that a write of 0xB to reg3 commits -> rdata=0xA; subsequent read returns 0xB.
- Assert rst while W held and AW absent -> after release, next AW+W to 0x00 writes reg0 with the new data only, exactly one bvalid.
